// File: rtl/qpsk_link_pkg.sv
// Shared types and helpers for the QPSK link phase-scan supervisor.
// Scan state encoding, default symbol geometry, saturating add and popcount.
package qpsk_link_pkg;

    localparam int LPS_UPSAMPLE = 4;
    localparam int LPS_PHASE_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_DECIDE  = 3'd3,
        ST_APPLY   = 3'd4,
        ST_LOCK    = 3'd5
    } lps_state_e;

    // Adds two counts and clamps the result at max_v.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] sum_s;
        sum_s = {1'b0, a} + {1'b0, b};
        if (sum_s > {1'b0, max_v}) begin
            sat_add = max_v;
        end else begin
            sat_add = sum_s[31:0];
        end
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n_s;
        n_s = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n_s = n_s + {5'd0, v[i]};
        end
        return n_s;
    endfunction

endpackage

// File: rtl/link_err_acc.sv
// Bit-error accumulator: counts mismatching bits between two NCH-wide words
// on each enabled clock, saturating at the all-ones count; clear wins over enable.
module link_err_acc
    import qpsk_link_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [NCH-1:0]   i_a,
    input  logic [NCH-1:0]   i_b,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating error count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_cnt <= '0;
        end else if (i_clr) begin
            o_cnt <= '0;
        end else if (i_en) begin
            o_cnt <= CNT_W'(sat_add(32'(o_cnt),
                                    32'(popcount32(32'(i_a ^ i_b))),
                                    32'(CNT_MAX)));
        end
    end

endmodule

// File: rtl/link_phase_scan.sv
// Receive-phase search and BER supervisor: scans every rx phase, locks on the
// lowest-error one, then keeps error/bit counters. PHASE_SCAN_RESCAN_EN enables auto-rescan.
module link_phase_scan
    import qpsk_link_pkg::*;
#(
    parameter int UPSAMPLE  = LPS_UPSAMPLE,
    parameter int PHASE_W   = LPS_PHASE_W,
    parameter int NCH       = 2,
    parameter int ALIGN_DLY = 0,
    parameter int SETTLE    = 64,
    parameter int WINDOW    = 1024,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [NCH-1:0]     i_sx,
    input  logic [NCH-1:0]     i_dx,
    output logic               o_enable_sym,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_enable_rx,
    output logic               o_busy,
    output logic               o_locked,
    output logic [CNT_W-1:0]   o_best_err,
    output logic [CNT_W-1:0]   o_err_cnt,
    output logic [CNT_W-1:0]   o_bit_cnt,
    output logic               o_error_flag
);

    localparam int MAX_SW = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int SCNT_W = $clog2(MAX_SW + 1);
    localparam int ERR_W  = $clog2(NCH + 1);
    localparam logic [SCNT_W-1:0]  SETTLE_LAST = SCNT_W'(SETTLE - 1);
    localparam logic [SCNT_W-1:0]  WIN_LAST    = SCNT_W'(WINDOW - 1);
    localparam logic [PHASE_W-1:0] LAST_PHASE  = PHASE_W'(UPSAMPLE - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

    lps_state_e         state_r;
    logic [PHASE_W-1:0] sym_div_r;
    logic [SCNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]   best_err_r;
    logic [PHASE_W-1:0] best_phase_r;
    logic [NCH-1:0]     sx_dly_s;
    logic [ERR_W-1:0]   err_n_s;
    logic [CNT_W-1:0]   win_err_s;
    logic               better_s;
    logic               win_clr_s;
    logic               win_en_s;
    logic               lock_enter_s;
    logic               lock_en_s;
    logic               rescan_s;
    logic               restart_s;
    logic               start_s;

    // Symbol divider; the strobe is registered so it lands on counter wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_div_r    <= '0;
            o_enable_sym <= 1'b0;
        end else begin
            o_enable_sym <= (sym_div_r == LAST_PHASE);
            if (sym_div_r == LAST_PHASE) begin
                sym_div_r <= '0;
            end else begin
                sym_div_r <= sym_div_r + PHASE_W'(1);
            end
        end
    end

    // Reference alignment: ALIGN_DLY symbols of strobe-clocked delay on i_sx.
    generate
        if (ALIGN_DLY == 0) begin : g_nodly
            assign sx_dly_s = i_sx;
        end else begin : g_dly
            logic [NCH-1:0] dly_r [ALIGN_DLY];

            // Shift the reference one stage per symbol strobe.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < ALIGN_DLY; i++) begin
                        dly_r[i] <= '0;
                    end
                end else if (o_enable_sym) begin
                    dly_r[0] <= i_sx;
                    for (int i = 1; i < ALIGN_DLY; i++) begin
                        dly_r[i] <= dly_r[i-1];
                    end
                end
            end

            assign sx_dly_s = dly_r[ALIGN_DLY-1];
        end
    endgenerate

    assign err_n_s  = ERR_W'(popcount32(32'(i_dx ^ sx_dly_s)));
    assign better_s = (win_err_s < best_err_r);

    // Accumulator control and scan (re)start qualification.
    always_comb begin
        win_clr_s    = (state_r == ST_SETTLE);
        win_en_s     = (state_r == ST_MEASURE) && o_enable_sym;
        lock_enter_s = (state_r == ST_APPLY) && o_enable_sym && (cnt_r == SETTLE_LAST);
        restart_s    = (state_r == ST_LOCK) && (i_start || rescan_s);
        lock_en_s    = (state_r == ST_LOCK) && o_enable_sym && !restart_s;
        start_s      = ((state_r == ST_IDLE) && i_start) || restart_s;
    end

    link_err_acc #(.NCH(NCH), .CNT_W(CNT_W)) u_win_acc (
        .clk   (clk),
        .rst   (rst),
        .i_clr (win_clr_s),
        .i_en  (win_en_s),
        .i_a   (i_dx),
        .i_b   (sx_dly_s),
        .o_cnt (win_err_s)
    );

    link_err_acc #(.NCH(NCH), .CNT_W(CNT_W)) u_lock_acc (
        .clk   (clk),
        .rst   (rst),
        .i_clr (lock_enter_s),
        .i_en  (lock_en_s),
        .i_a   (i_dx),
        .i_b   (sx_dly_s),
        .o_cnt (o_err_cnt)
    );

`ifdef PHASE_SCAN_RESCAN_EN
    localparam int RESCAN_THR = WINDOW / 64;

    logic [SCNT_W-1:0] blk_cnt_r;
    logic [CNT_W-1:0]  blk_err_r;
    logic [CNT_W-1:0]  blk_sum_s;

    assign blk_sum_s = CNT_W'(sat_add(32'(blk_err_r), 32'(err_n_s), 32'(CNT_MAX)));
    assign rescan_s  = (state_r == ST_LOCK) && o_enable_sym && (blk_cnt_r == WIN_LAST)
                       && (32'(blk_sum_s) > 32'(RESCAN_THR));

    // Per-block error tally while locked; a block ends every WINDOW symbols.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_cnt_r <= '0;
            blk_err_r <= '0;
        end else if (state_r != ST_LOCK) begin
            blk_cnt_r <= '0;
            blk_err_r <= '0;
        end else if (o_enable_sym) begin
            if (blk_cnt_r == WIN_LAST) begin
                blk_cnt_r <= '0;
                blk_err_r <= '0;
            end else begin
                blk_cnt_r <= blk_cnt_r + SCNT_W'(1);
                blk_err_r <= blk_sum_s;
            end
        end
    end
`else
    assign rescan_s = 1'b0;
`endif

    // Scan FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            best_err_r   <= '1;
            best_phase_r <= '0;
            o_phase      <= '0;
            o_enable_rx  <= 1'b0;
            o_busy       <= 1'b0;
            o_locked     <= 1'b0;
            o_best_err   <= '0;
            o_bit_cnt    <= '0;
            o_error_flag <= 1'b0;
        end else if (start_s) begin
            state_r      <= ST_SETTLE;
            cnt_r        <= '0;
            best_err_r   <= '1;
            best_phase_r <= '0;
            o_phase      <= '0;
            o_enable_rx  <= 1'b1;
            o_busy       <= 1'b1;
            o_locked     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                end
                ST_SETTLE: begin
                    if (o_enable_sym) begin
                        if (cnt_r == SETTLE_LAST) begin
                            cnt_r   <= '0;
                            state_r <= ST_MEASURE;
                        end else begin
                            cnt_r <= cnt_r + SCNT_W'(1);
                        end
                    end
                end
                ST_MEASURE: begin
                    if (o_enable_sym) begin
                        if (cnt_r == WIN_LAST) begin
                            cnt_r   <= '0;
                            state_r <= ST_DECIDE;
                        end else begin
                            cnt_r <= cnt_r + SCNT_W'(1);
                        end
                    end
                end
                ST_DECIDE: begin
                    // Strict compare keeps the lowest phase on ties.
                    if (better_s) begin
                        best_err_r   <= win_err_s;
                        best_phase_r <= o_phase;
                    end
                    cnt_r <= '0;
                    if (o_phase == LAST_PHASE) begin
                        state_r    <= ST_APPLY;
                        o_phase    <= better_s ? o_phase : best_phase_r;
                        o_best_err <= better_s ? win_err_s : best_err_r;
                    end else begin
                        state_r <= ST_SETTLE;
                        o_phase <= o_phase + PHASE_W'(1);
                    end
                end
                ST_APPLY: begin
                    if (lock_enter_s) begin
                        cnt_r        <= '0;
                        state_r      <= ST_LOCK;
                        o_busy       <= 1'b0;
                        o_locked     <= 1'b1;
                        o_bit_cnt    <= '0;
                        o_error_flag <= 1'b0;
                    end else if (o_enable_sym) begin
                        cnt_r <= cnt_r + SCNT_W'(1);
                    end
                end
                ST_LOCK: begin
                    if (lock_en_s) begin
                        o_bit_cnt <= CNT_W'(sat_add(32'(o_bit_cnt), 32'(NCH), 32'(CNT_MAX)));
                        if (err_n_s != '0) begin
                            o_error_flag <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_link_phase_scan.sv
// Scoreboard bench for link_phase_scan: directed scans with a phase-dependent rx model;
// expectations are queued by the stimulus and checked by an independent monitor.
module tb_link_phase_scan;

    typedef struct {
        int locked;
        int busy;
        int rx;
        int phase;
        int best;
        int err;
        int bits;
        int flag;
    } snap_t;

    logic       clk;
    logic       rst;
    logic       i_start;
    logic [1:0] i_sx;
    logic [1:0] i_dx;
    logic       o_enable_sym;
    logic [1:0] o_phase;
    logic       o_enable_rx;
    logic       o_busy;
    logic       o_locked;
    logic [3:0] o_best_err;
    logic [3:0] o_err_cnt;
    logic [3:0] o_bit_cnt;
    logic       o_error_flag;

    logic [1:0] mask_tbl [4];
    logic [1:0] inj;
    logic       cont_err;

    int    n_cmp;
    int    n_fail;
    snap_t snap_q [$];
    snap_t lock_q [$];
    int    per_q  [$];

    link_phase_scan #(
        .UPSAMPLE(4), .PHASE_W(2), .NCH(2), .ALIGN_DLY(0),
        .SETTLE(4), .WINDOW(16), .CNT_W(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_sx         (i_sx),
        .i_dx         (i_dx),
        .o_enable_sym (o_enable_sym),
        .o_phase      (o_phase),
        .o_enable_rx  (o_enable_rx),
        .o_busy       (o_busy),
        .o_locked     (o_locked),
        .o_best_err   (o_best_err),
        .o_err_cnt    (o_err_cnt),
        .o_bit_cnt    (o_bit_cnt),
        .o_error_flag (o_error_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t mk(int l, int b, int r, int p, int be, int e, int bc, int f);
        snap_t s;
        s.locked = l; s.busy = b; s.rx = r; s.phase = p;
        s.best = be; s.err = e; s.bits = bc; s.flag = f;
        return s;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_snap(input string nm, input snap_t s);
        chk({nm, ".locked"}, int'(o_locked), s.locked);
        chk({nm, ".busy"},   int'(o_busy), s.busy);
        chk({nm, ".rx_en"},  int'(o_enable_rx), s.rx);
        chk({nm, ".phase"},  int'(o_phase), s.phase);
        chk({nm, ".best"},   int'(o_best_err), s.best);
        chk({nm, ".errcnt"}, int'(o_err_cnt), s.err);
        chk({nm, ".bitcnt"}, int'(o_bit_cnt), s.bits);
        chk({nm, ".flag"},   int'(o_error_flag), s.flag);
    endtask

    // Rx model: decided bits equal the reference except where the phase mask flips them.
    initial begin
        logic [1:0] sx;
        logic [1:0] m;
        i_sx = 2'b00;
        i_dx = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            sx = 2'($urandom);
            m  = mask_tbl[o_phase];
            if (cont_err) m = 2'b11;
            if (o_enable_sym && (inj != 2'b00)) begin
                m   = m ^ inj;
                inj = 2'b00;
            end
            i_sx = sx;
            i_dx = sx ^ m;
        end
    end

    // Monitor: pops expectations when the DUT presents a lock, a strobe or a snapshot request.
    initial begin
        int    gap;
        bit    seen;
        bit    locked_prev;
        snap_t s;
        gap = 0; seen = 1'b0; locked_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                gap  = 0;
                seen = 1'b0;
            end else begin
                gap++;
                if (o_enable_sym) begin
                    if (seen && per_q.size() > 0) chk("strobe_period", gap, per_q.pop_front());
                    seen = 1'b1;
                    gap  = 0;
                end
            end
            if (o_locked && !locked_prev) begin
                if (lock_q.size() == 0) begin
                    chk("unexpected_lock", 1, 0);
                end else begin
                    s = lock_q.pop_front();
                    cmp_snap("lock", s);
                end
            end
            locked_prev = o_locked;
            if (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                cmp_snap("snap", s);
            end
        end
    end

    task automatic set_masks(input logic [1:0] a, input logic [1:0] b,
                             input logic [1:0] c, input logic [1:0] d);
        mask_tbl[0] = a; mask_tbl[1] = b; mask_tbl[2] = c; mask_tbl[3] = d;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_strobes(input int n);
        int c = 0;
        int t = 0;
        while (c < n && t < 10 * n + 20) begin
            @(negedge clk);
            t++;
            if (o_enable_sym) c++;
        end
        if (c < n) chk("strobe_timeout", c, n);
        @(negedge clk);
    endtask

    task automatic wait_lock();
        int n = 0;
        while (!o_locked && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!o_locked) begin
            chk("lock_timeout", 0, 1);
            if (lock_q.size() > 0) void'(lock_q.pop_front());
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b0; i_start = 1'b0; inj = 2'b00; cont_err = 1'b0;
        set_masks(2'b11, 2'b11, 2'b00, 2'b11);
        repeat (3) @(negedge clk);
        snap_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) per_q.push_back(4);
        repeat (16) @(negedge clk);

        // Only phase 2 clean: scan all four phases and lock on 2.
        pulse_start();
        snap_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
        lock_q.push_back(mk(1, 0, 1, 2, 0, 0, 0, 0));
        wait_lock();

        // One I-bit error in lock; bit count grows by 2 per symbol then saturates.
        inj = 2'b01;
        wait_strobes(3);
        snap_q.push_back(mk(1, 0, 1, 2, 0, 1, 6, 1));
        wait_strobes(5);
        snap_q.push_back(mk(1, 0, 1, 2, 0, 1, 15, 1));

        // Restart from lock with phases 1 and 3 both clean: lowest index wins.
        set_masks(2'b11, 2'b00, 2'b11, 2'b00);
        pulse_start();
        snap_q.push_back(mk(0, 1, 1, 0, 0, 1, 15, 1));
        lock_q.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0));
        wait_lock();

        // Continuous errors: error count clamps at 15.
        cont_err = 1'b1;
        wait_strobes(9);
        snap_q.push_back(mk(1, 0, 1, 1, 0, 15, 15, 1));
        wait_strobes(1);
        snap_q.push_back(mk(1, 0, 1, 1, 0, 15, 15, 1));
        cont_err = 1'b0;

        // Start pulse during the phase-1 window is ignored.
        set_masks(2'b00, 2'b11, 2'b11, 2'b11);
        pulse_start();
        wait_strobes(30);
        pulse_start();
        snap_q.push_back(mk(0, 1, 1, 1, 0, 15, 15, 1));
        lock_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
        wait_lock();

        // Reset in the middle of a scan clears everything and parks in idle.
        pulse_start();
        wait_strobes(10);
        rst = 1'b0;
        snap_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) per_q.push_back(4);
        repeat (20) @(negedge clk);
        snap_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

        // Lock on phase 2, then the channel degrades at that phase.
        set_masks(2'b11, 2'b11, 2'b00, 2'b11);
        pulse_start();
        lock_q.push_back(mk(1, 0, 1, 2, 0, 0, 0, 0));
        wait_lock();
        set_masks(2'b00, 2'b11, 2'b11, 2'b11);
`ifdef PHASE_SCAN_RESCAN_EN
        begin
            int n = 0;
            while (o_locked && n < 600) begin
                @(negedge clk);
                n++;
            end
            chk("rescan_drop", int'(o_locked), 0);
        end
        lock_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
        wait_lock();
`else
        wait_strobes(40);
        snap_q.push_back(mk(1, 0, 1, 2, 0, 15, 15, 1));
`endif

        repeat (4) @(negedge clk);
        chk("lock_q_left", lock_q.size(), 0);
        chk("snap_q_left", snap_q.size(), 0);
        chk("per_q_left", per_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
